// File: rtl/photonic_output_packer.sv
// Packs PRECISION-bit layer results into OUTPUT_WIDTH words (lane 0 first) and
// queues them in a FWFT FIFO. Optional partial-word flush: define PACK_TIMEOUT_EN.
module photonic_output_packer #(
    parameter int PRECISION      = 8,
    parameter int OUTPUT_WIDTH   = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [PRECISION-1:0]                              s_data,
    input  logic                                              s_valid,
    output logic [OUTPUT_WIDTH-1:0]                           m_data,
    output logic                                              m_valid,
    input  logic                                              m_ready,
    output logic [$clog2(OUTPUT_WIDTH/PRECISION):0]           m_lanes,
    output logic [$clog2(FIFO_DEPTH):0]                       fifo_level,
    output logic                                              overflow
);

    localparam int LANES = OUTPUT_WIDTH / PRECISION;
    localparam int CNT_W = $clog2(LANES) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] LAST_LANE  = CNT_W'(LANES - 1);
    localparam logic [CNT_W-1:0] FULL_LANES = CNT_W'(LANES);
    localparam logic [LVL_W-1:0] DEPTH_LVL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic {
        ST_EMPTY,
        ST_PARTIAL
    } pack_state_t;

    pack_state_t             state;
    logic [CNT_W-1:0]        count;
    logic [OUTPUT_WIDTH-1:0] pack_reg;

    logic [OUTPUT_WIDTH-1:0] mem_data  [FIFO_DEPTH];
    logic [CNT_W-1:0]        mem_lanes [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [LVL_W-1:0]        level;
    logic [OUTPUT_WIDTH-1:0] head_data;
    logic [CNT_W-1:0]        head_lanes;
    logic                    ovf_flag;

    logic                    push_req;
    logic                    flush_req;
    logic [OUTPUT_WIDTH-1:0] push_data;
    logic [CNT_W-1:0]        push_lanes;
    logic                    pop;
    logic                    push_acc;
    logic [PTR_W-1:0]        rd_ptr_n;
    logic [LVL_W-1:0]        level_n;
    logic [OUTPUT_WIDTH-1:0] head_data_n;
    logic [CNT_W-1:0]        head_lanes_n;

`ifdef PACK_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_FIRE = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] timer;

    // The flush fires on the idle edge that brings the timer to TIMEOUT_CYCLES.
    assign flush_req = (state == ST_PARTIAL) && !s_valid && (timer >= TMR_FIRE);
`else
    assign flush_req = 1'b0;
`endif

    always_comb begin
        push_req   = 1'b0;
        push_data  = pack_reg;
        push_lanes = FULL_LANES;
        if (s_valid && (count == LAST_LANE)) begin
            push_req = 1'b1;
            push_data[(LANES-1)*PRECISION +: PRECISION] = s_data;
        end else if (flush_req) begin
            push_req   = 1'b1;
            push_lanes = count;
        end
    end

    assign pop      = (level != '0) && m_ready;
    assign push_acc = push_req && ((level != DEPTH_LVL) || pop);
    assign rd_ptr_n = pop ? rd_ptr + 1'b1 : rd_ptr;

    // Head for the next cycle: a word written into the new head slot this edge
    // only happens when the FIFO drains to that single word.
    always_comb begin
        level_n = level;
        case ({push_acc, pop})
            2'b10:   level_n = level + 1'b1;
            2'b01:   level_n = level - 1'b1;
            default: level_n = level;
        endcase
        head_data_n  = head_data;
        head_lanes_n = head_lanes;
        if (level_n != '0) begin
            if (push_acc && (wr_ptr == rd_ptr_n)) begin
                head_data_n  = push_data;
                head_lanes_n = push_lanes;
            end else begin
                head_data_n  = mem_data[rd_ptr_n];
                head_lanes_n = mem_lanes[rd_ptr_n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            count    <= '0;
            pack_reg <= '0;
`ifdef PACK_TIMEOUT_EN
            timer    <= '0;
`endif
        end else if (s_valid) begin
`ifdef PACK_TIMEOUT_EN
            timer <= '0;
`endif
            if (count == LAST_LANE) begin
                state    <= ST_EMPTY;
                count    <= '0;
                pack_reg <= '0;
            end else begin
                state <= ST_PARTIAL;
                count <= count + 1'b1;
                if (state == ST_EMPTY)
                    pack_reg <= OUTPUT_WIDTH'(s_data);
                else
                    pack_reg[count*PRECISION +: PRECISION] <= s_data;
            end
        end
`ifdef PACK_TIMEOUT_EN
        else if (state == ST_PARTIAL) begin
            // A blocked flush keeps the partial word and retries next cycle.
            if (flush_req && push_acc) begin
                state    <= ST_EMPTY;
                count    <= '0;
                pack_reg <= '0;
                timer    <= '0;
            end else if (timer != TMR_MAX) begin
                timer <= timer + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            head_data  <= '0;
            head_lanes <= '0;
            ovf_flag   <= 1'b0;
        end else begin
            if (push_acc) begin
                mem_data[wr_ptr]  <= push_data;
                mem_lanes[wr_ptr] <= push_lanes;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (push_req && !push_acc && !flush_req)
                ovf_flag <= 1'b1;
            rd_ptr     <= rd_ptr_n;
            level      <= level_n;
            head_data  <= head_data_n;
            head_lanes <= head_lanes_n;
        end
    end

    assign m_data     = head_data;
    assign m_lanes    = head_lanes;
    assign m_valid    = (level != '0);
    assign fifo_level = level;
    assign overflow   = ovf_flag;

endmodule

// File: tb/tb_photonic_output_packer.sv
// Randomised + directed bench for photonic_output_packer against a queue-based
// reference model; the timeout scenario follows PACK_TIMEOUT_EN.
module tb_photonic_output_packer;

    localparam int P     = 8;
    localparam int OW    = 32;
    localparam int LANES = OW / P;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [P-1:0]  s_data;
    logic          s_valid;
    logic [OW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [2:0]    m_lanes;
    logic [2:0]    fifo_level;
    logic          overflow;

    int compared   = 0;
    int mismatched = 0;

    logic [OW-1:0] mq_data[$];
    int            mq_lanes[$];
    logic [P-1:0]  mpart[$];
    bit            movf;
    logic [OW-1:0] mlast_data;
    int            mlast_lanes;
    int            midle;

    photonic_output_packer #(
        .PRECISION(P), .OUTPUT_WIDTH(OW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_lanes(m_lanes), .fifo_level(fifo_level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: samples accumulate in a list; a full list (or a timed-out partial)
    // becomes a word appended to a bounded queue, consumer pops first.
    task automatic modelStep(input bit r, input bit sv, input logic [P-1:0] d, input bit rdy);
        bit            pop;
        bit            have;
        bit            flush;
        logic [OW-1:0] word;
        int            lanes;
        if (r) begin
            mq_data.delete(); mq_lanes.delete(); mpart.delete();
            movf = 0; mlast_data = '0; mlast_lanes = 0; midle = 0;
            return;
        end
        pop = (mq_data.size() > 0) && rdy;
        have = 0; flush = 0; word = '0; lanes = 0;
        if (sv) begin
            mpart.push_back(d);
            midle = 0;
            if (mpart.size() == LANES) begin
                have = 1; lanes = LANES;
                for (int i = 0; i < LANES; i++) word = word | (OW'(mpart[i]) << (P * i));
                mpart.delete();
            end
        end else if (mpart.size() > 0) begin
            midle++;
`ifdef PACK_TIMEOUT_EN
            if (midle >= TMO) begin
                have = 1; flush = 1; lanes = mpart.size();
                for (int i = 0; i < mpart.size(); i++) word = word | (OW'(mpart[i]) << (P * i));
            end
`endif
        end
        if (pop) begin
            void'(mq_data.pop_front());
            void'(mq_lanes.pop_front());
        end
        if (have) begin
            if (mq_data.size() < DEPTH) begin
                mq_data.push_back(word);
                mq_lanes.push_back(lanes);
                if (flush) begin
                    mpart.delete();
                    midle = 0;
                end
            end else if (!flush) begin
                movf = 1;
            end
        end
        if (mq_data.size() > 0) begin
            mlast_data  = mq_data[0];
            mlast_lanes = mq_lanes[0];
        end
    endtask

    task automatic applyStimulus(input bit r, input bit sv, input logic [P-1:0] d, input bit rdy);
        rst = r; s_valid = sv; s_data = d; m_ready = rdy;
        modelStep(r, sv, d, rdy);
        @(posedge clk);
        #1;
        checkOutput("m_valid", OW'(m_valid), OW'(mq_data.size() != 0));
        checkOutput("m_data", m_data, mlast_data);
        checkOutput("m_lanes", OW'(m_lanes), OW'(mlast_lanes));
        checkOutput("fifo_level", OW'(fifo_level), OW'(mq_data.size()));
        checkOutput("overflow", OW'(overflow), OW'(movf));
    endtask

    initial begin
        logic [OW-1:0] drain_exp [4];
        drain_exp[0] = 32'h03020100; drain_exp[1] = 32'h07060504;
        drain_exp[2] = 32'h0B0A0908; drain_exp[3] = 32'h0F0E0D0C;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        movf = 0; mlast_data = '0; mlast_lanes = 0; midle = 0;

        applyStimulus(1, 1, 8'hFF, 1);
        applyStimulus(1, 0, 8'h00, 0);
        checkOutput("reset_valid", OW'(m_valid), '0);
        checkOutput("reset_data", m_data, '0);
        checkOutput("reset_lanes", OW'(m_lanes), '0);

        // Basic pack
        applyStimulus(0, 1, 8'h11, 1);
        applyStimulus(0, 1, 8'h22, 1);
        applyStimulus(0, 1, 8'h33, 1);
        checkOutput("basic_not_yet", OW'(m_valid), '0);
        applyStimulus(0, 1, 8'h44, 1);
        checkOutput("basic_data", m_data, 32'h44332211);
        checkOutput("basic_lanes", OW'(m_lanes), 32'd4);
        checkOutput("basic_valid", OW'(m_valid), 32'd1);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("basic_one_cycle", OW'(m_valid), '0);

        // Fill, overflow, drain in order
        for (int i = 0; i < 16; i++) applyStimulus(0, 1, P'(i), 0);
        checkOutput("fill_level", OW'(fifo_level), 32'd4);
        checkOutput("fill_ovf", OW'(overflow), '0);
        for (int i = 16; i < 20; i++) applyStimulus(0, 1, P'(i), 0);
        checkOutput("drop_ovf", OW'(overflow), 32'd1);
        checkOutput("drop_level", OW'(fifo_level), 32'd4);
        for (int k = 0; k < 4; k++) begin
            checkOutput("drain_order", m_data, drain_exp[k]);
            applyStimulus(0, 0, 8'h00, 1);
        end
        checkOutput("drain_empty", OW'(m_valid), '0);
        checkOutput("ovf_sticky", OW'(overflow), 32'd1);

        // Simultaneous push and pop while full
        applyStimulus(1, 0, 8'h00, 0);
        checkOutput("ovf_cleared", OW'(overflow), '0);
        for (int i = 0; i < 16; i++) applyStimulus(0, 1, P'(8'h60 + i), 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, P'(8'h30 + i), 0);
        applyStimulus(0, 1, 8'h33, 1);
        checkOutput("pushpop_level", OW'(fifo_level), 32'd4);
        checkOutput("pushpop_ovf", OW'(overflow), '0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'h00, 1);
        checkOutput("pushpop_last", m_data, 32'h33323130);
        applyStimulus(0, 0, 8'h00, 1);

        // Reset mid-word
        applyStimulus(0, 1, 8'h01, 0);
        applyStimulus(0, 1, 8'h02, 0);
        applyStimulus(1, 1, 8'h03, 0);
        checkOutput("midrst_valid", OW'(m_valid), '0);
        checkOutput("midrst_ovf", OW'(overflow), '0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, P'(8'hA1 + i), 1);
        checkOutput("midrst_word", m_data, 32'hA4A3A2A1);

        // Partial word: flushed after the timeout or held forever
        applyStimulus(1, 0, 8'h00, 1);
        applyStimulus(0, 1, 8'h55, 1);
        applyStimulus(0, 1, 8'h66, 1);
`ifdef PACK_TIMEOUT_EN
        for (int i = 0; i < TMO; i++) applyStimulus(0, 0, 8'h00, 1);
        checkOutput("tmo_valid", OW'(m_valid), 32'd1);
        checkOutput("tmo_data", m_data, 32'h00006655);
        checkOutput("tmo_lanes", OW'(m_lanes), 32'd2);
`else
        for (int i = 0; i < 100; i++) applyStimulus(0, 0, 8'h00, 1);
        checkOutput("hold_partial", OW'(m_valid), '0);
`endif

        // Randomised traffic with phases of heavy and light backpressure
        applyStimulus(1, 0, 8'h00, 0);
        for (int i = 0; i < 3000; i++) begin
            int rdy_pct;
            rdy_pct = ((i / 200) % 3 == 0) ? 10 : (((i / 200) % 3 == 1) ? 90 : 50);
            applyStimulus($urandom_range(0, 299) == 0,
                          $urandom_range(0, 99) < 60,
                          P'($urandom),
                          $urandom_range(0, 99) < rdy_pct);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
